// File: rtl/block_pkg.sv
// Shared types and constants for the block scheduler.
// Holds the FSM state encoding, default widths, the default timeout and the
// slot-index width used by op_sel, plus a one-hot to index helper.
package block_pkg;

  localparam int unsigned BLK_DW   = 4;
  localparam int unsigned BLK_NREQ = 4;
  localparam int unsigned BLK_TMO  = 15;
  localparam int unsigned SEL_W    = $clog2(BLK_NREQ);
  // Timeout counter wide enough for TMO up to 255.
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_START,
    ST_WAIT,
    ST_HOLD
  } state_t;

  // Encode a one-hot (or zero) vector as a slot index.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [BLK_NREQ-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(BLK_NREQ); i++) begin
      if (v[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/block_scheduler_if.sv
// Bundle of requester, compute-block and result-consumer signals.
// slave  : scheduler side (drives gnt/op_*/blk_start/res_*/busy/err_tmo)
// master : environment side (drives req/req_data/blk_done/blk_result/res_ready)
interface block_scheduler_if #(
  parameter int unsigned DW   = block_pkg::BLK_DW,
  parameter int unsigned NREQ = block_pkg::BLK_NREQ
);
  import block_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               op_load;
  logic [SEL_W-1:0]   op_sel;
  logic [DW-1:0]      op_data;
  logic               blk_start;
  logic               blk_done;
  logic [DW-1:0]      blk_result;
  logic               res_valid;
  logic [DW-1:0]      res_data;
  logic               res_ready;
  logic               busy;
  logic               err_tmo;

  modport slave (
    input  req, req_data, blk_done, blk_result, res_ready,
    output gnt, op_load, op_sel, op_data, blk_start, res_valid, res_data,
           busy, err_tmo
  );

  modport master (
    output req, req_data, blk_done, blk_result, res_ready,
    input  gnt, op_load, op_sel, op_data, blk_start, res_valid, res_data,
           busy, err_tmo
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first unmasked request at or above ptr,
// wrapping around. Purely combinational.
// Ports: req (requests), mask (slots excluded), ptr (search start),
//        grant (one-hot, zero when nothing is eligible).
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] elig;
  assign elig = req & ~mask;

  // Scan NREQ positions starting at ptr; first eligible one wins.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = PW'((32'(ptr) + 32'(i)) % NREQ);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Collects one operand per requester into a compute block via round-robin
// grants, starts the block, waits (with timeout) for its result and holds
// the result until the consumer accepts it.
// Ports: clk, rst (sync, active-high), bus (block_scheduler_if.slave).
module block_scheduler
  import block_pkg::*;
#(
  parameter int unsigned DW   = BLK_DW,
  parameter int unsigned NREQ = BLK_NREQ,
  parameter int unsigned TMO  = BLK_TMO
) (
  input logic              clk,
  input logic              rst,
  block_scheduler_if.slave bus
);

  state_t             state_q, state_d;
  logic [NREQ-1:0]    mask_q, mask_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               op_load_q, op_load_d;
  logic [SEL_W-1:0]   op_sel_q, op_sel_d;
  logic [DW-1:0]      op_data_q, op_data_d;
  logic               blk_start_q, blk_start_d;
  logic               res_valid_q, res_valid_d;
  logic [DW-1:0]      res_data_q, res_data_d;
  logic               busy_q;
  logic               err_q, err_d;
  logic [NREQ-1:0]    grant_c;
  logic [SEL_W-1:0]   gidx_c;

  rr_arbiter #(.NREQ(NREQ), .PW(SEL_W)) u_arb (
    .req   (bus.req),
    .mask  (mask_q),
    .ptr   (ptr_q),
    .grant (grant_c)
  );

  assign gidx_c = onehot_to_idx(grant_c);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      mask_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      op_load_q   <= 1'b0;
      op_sel_q    <= '0;
      op_data_q   <= '0;
      blk_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      op_load_q   <= op_load_d;
      op_sel_q    <= op_sel_d;
      op_data_q   <= op_data_d;
      blk_start_q <= blk_start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= (state_d != ST_COLLECT);
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    op_load_d   = 1'b0;
    op_sel_d    = op_sel_q;
    op_data_d   = op_data_q;
    blk_start_d = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;

    unique case (state_q)
      ST_COLLECT: begin
        // A full mask was registered by the last grant: start next cycle.
        if (&mask_q) begin
          state_d     = ST_START;
          blk_start_d = 1'b1;
        end else if (|grant_c) begin
          gnt_d     = grant_c;
          op_load_d = 1'b1;
          op_sel_d  = gidx_c;
          op_data_d = bus.req_data[32'(gidx_c)*DW +: DW];
          mask_d    = mask_q | grant_c;
          ptr_d     = (gidx_c == SEL_W'(NREQ - 1)) ? '0 : gidx_c + SEL_W'(1);
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // blk_done wins over a timeout falling in the same cycle.
        if (bus.blk_done) begin
          res_data_d  = bus.blk_result;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (cnt_q + CNT_W'(1) == CNT_W'(TMO)) begin
          err_d   = 1'b1;
          mask_d  = '0;
          cnt_d   = '0;
          state_d = ST_COLLECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          mask_d      = '0;
          state_d     = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.op_load   = op_load_q;
  assign bus.op_sel    = op_sel_q;
  assign bus.op_data   = op_data_q;
  assign bus.blk_start = blk_start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = busy_q;
  assign bus.err_tmo   = err_q;

endmodule

// File: tb/tb_block_scheduler.sv
// Self-checking bench for block_scheduler: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a transaction-level
// reference model.
module tb_block_scheduler;
  import block_pkg::*;

  localparam int unsigned DW   = BLK_DW;
  localparam int unsigned NREQ = BLK_NREQ;
  localparam int unsigned TMO  = 3;
  localparam int          NR   = int'(NREQ);
  localparam int          TM   = int'(TMO);

  localparam int P_COLLECT = 0;
  localparam int P_START   = 1;
  localparam int P_WAIT    = 2;
  localparam int P_HOLD    = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  block_scheduler_if #(.DW(DW), .NREQ(NREQ)) bus ();

  block_scheduler #(.DW(DW), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  int               ph;
  bit               loaded [NREQ];
  int               rrp;
  int               wcnt;
  logic [NREQ-1:0]  e_gnt;
  logic             e_load;
  logic [SEL_W-1:0] e_sel;
  logic [DW-1:0]    e_opd;
  logic             e_start;
  logic             e_rv;
  logic [DW-1:0]    e_rd;
  logic             e_busy;
  logic             e_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic clear_loaded();
    for (int k = 0; k < NR; k++) loaded[k] = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit all_in;
    int pick;
    int s;
    e_gnt   = '0;
    e_load  = 1'b0;
    e_start = 1'b0;
    if (rst) begin
      ph = P_COLLECT;
      clear_loaded();
      rrp    = 0;
      wcnt   = 0;
      e_sel  = '0;
      e_opd  = '0;
      e_rv   = 1'b0;
      e_rd   = '0;
      e_err  = 1'b0;
      e_busy = 1'b0;
      return;
    end
    case (ph)
      P_COLLECT: begin
        all_in = 1'b1;
        for (int k = 0; k < NR; k++) if (!loaded[k]) all_in = 1'b0;
        if (all_in) begin
          ph      = P_START;
          e_start = 1'b1;
        end else begin
          pick = -1;
          for (int k = 0; k < NR; k++) begin
            s = (rrp + k) % NR;
            if (pick < 0 && bus.req[s] && !loaded[s]) pick = s;
          end
          if (pick >= 0) begin
            e_gnt[pick] = 1'b1;
            e_load      = 1'b1;
            e_sel       = SEL_W'(pick);
            e_opd       = bus.req_data[pick*NR +: DW];
            loaded[pick] = 1'b1;
            rrp          = (pick + 1) % NR;
          end
        end
      end
      P_START: begin
        ph   = P_WAIT;
        wcnt = 0;
      end
      P_WAIT: begin
        if (bus.blk_done) begin
          e_rv = 1'b1;
          e_rd = bus.blk_result;
          ph   = P_HOLD;
        end else begin
          wcnt++;
          if (wcnt == TM) begin
            e_err = 1'b1;
            clear_loaded();
            ph = P_COLLECT;
          end
        end
      end
      default: begin
        if (bus.res_ready) begin
          e_rv = 1'b0;
          clear_loaded();
          ph = P_COLLECT;
        end
      end
    endcase
    e_busy = (ph != P_COLLECT);
  endtask

  // One clock: model predicts, DUT is compared on the falling edge.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".gnt"},       32'(bus.gnt),       32'(e_gnt));
    chk({tag, ".op_load"},   32'(bus.op_load),   32'(e_load));
    chk({tag, ".op_sel"},    32'(bus.op_sel),    32'(e_sel));
    chk({tag, ".op_data"},   32'(bus.op_data),   32'(e_opd));
    chk({tag, ".blk_start"}, 32'(bus.blk_start), 32'(e_start));
    chk({tag, ".res_valid"}, 32'(bus.res_valid), 32'(e_rv));
    chk({tag, ".res_data"},  32'(bus.res_data),  32'(e_rd));
    chk({tag, ".busy"},      32'(bus.busy),      32'(e_busy));
    chk({tag, ".err_tmo"},   32'(bus.err_tmo),   32'(e_err));
  endtask

  // Requesters drop their request once they see the grant.
  task automatic drop_granted();
    bus.req = bus.req & ~bus.gnt;
  endtask

  task automatic fill_all(input string tag);
    bus.req      = '1;
    bus.req_data = (NREQ*DW)'({$urandom, $urandom});
    for (int k = 0; k < NR; k++) begin
      step(tag);
      drop_granted();
    end
  endtask

  int starts;
  int rv_seen;

  initial begin
    rst            = 1'b1;
    bus.req        = '0;
    bus.req_data   = '0;
    bus.blk_done   = 1'b0;
    bus.blk_result = '0;
    bus.res_ready  = 1'b0;
    ph = P_COLLECT;
    clear_loaded();
    rrp = 0; wcnt = 0;
    e_gnt = '0; e_load = 1'b0; e_sel = '0; e_opd = '0; e_start = 1'b0;
    e_rv = 1'b0; e_rd = '0; e_busy = 1'b0; e_err = 1'b0;
    @(negedge clk);

    step("rst");
    step("rst");
    chk("rst_gnt",  32'(bus.gnt),     32'h0);
    chk("rst_busy", 32'(bus.busy),    32'h0);
    chk("rst_err",  32'(bus.err_tmo), 32'h0);

    // Scenario 1: four requests, operands 1..4, result 0xA.
    rst          = 1'b0;
    bus.req      = 4'b1111;
    bus.req_data = 16'h4321;
    for (int k = 0; k < 4; k++) begin
      step("s1");
      chk("s1_gnt_order", 32'(bus.gnt),     32'(1 << k));
      chk("s1_op_data",   32'(bus.op_data), 32'(k + 1));
      drop_granted();
    end
    step("s1");
    chk("s1_blk_start", 32'(bus.blk_start), 32'h1);
    step("s1");
    bus.blk_done   = 1'b1;
    bus.blk_result = 4'hA;
    step("s1");
    bus.blk_done = 1'b0;
    chk("s1_res_valid", 32'(bus.res_valid), 32'h1);
    chk("s1_res_data",  32'(bus.res_data),  32'hA);
    bus.res_ready = 1'b1;
    step("s1");
    bus.res_ready = 1'b0;

    // Scenario 2: split requests, grants follow the retained pointer.
    bus.req = 4'b0110;
    step("s2"); chk("s2_gnt1", 32'(bus.gnt), 32'h2); drop_granted();
    step("s2"); chk("s2_gnt2", 32'(bus.gnt), 32'h4); drop_granted();
    bus.req = 4'b1001;
    step("s2"); chk("s2_gnt3", 32'(bus.gnt), 32'h8); drop_granted();
    step("s2"); chk("s2_gnt0", 32'(bus.gnt), 32'h1); drop_granted();

    // Scenario 3: no blk_done, timeout after TMO wait cycles.
    starts  = 0;
    rv_seen = 0;
    for (int k = 0; k < 4; k++) begin
      step("s3");
      starts  += int'(bus.blk_start);
      rv_seen += int'(bus.res_valid);
      chk("s3_err_early", 32'(bus.err_tmo), 32'h0);
    end
    step("s3");
    starts  += int'(bus.blk_start);
    rv_seen += int'(bus.res_valid);
    chk("s2_one_start", 32'(starts),       32'h1);
    chk("s3_err",       32'(bus.err_tmo),  32'h1);
    chk("s3_idle",      32'(bus.busy),     32'h0);
    chk("s3_no_rv",     32'(rv_seen),      32'h0);
    step("s3");

    // Scenario 4: blk_done on the last allowed wait cycle wins.
    rst = 1'b1;
    step("s4");
    rst = 1'b0;
    fill_all("s4");
    step("s4");
    step("s4");
    step("s4");
    step("s4");
    bus.blk_done   = 1'b1;
    bus.blk_result = 4'h5;
    step("s4");
    bus.blk_done = 1'b0;
    chk("s4_res_valid", 32'(bus.res_valid), 32'h1);
    chk("s4_no_err",    32'(bus.err_tmo),   32'h0);

    // Scenario 5: consumer stalls; result stable, no grants until handshake.
    bus.req = '1;
    for (int k = 0; k < 10; k++) begin
      step("s5");
      chk("s5_hold_rv",   32'(bus.res_valid), 32'h1);
      chk("s5_hold_data", 32'(bus.res_data),  32'h5);
      chk("s5_no_gnt",    32'(bus.gnt),       32'h0);
    end
    bus.res_ready = 1'b1;
    step("s5");
    bus.res_ready = 1'b0;
    step("s5");
    chk("s5_regrant", 32'(bus.gnt), 32'h1);
    drop_granted();

    // Scenario 6: reset in WAIT abandons the transaction.
    for (int k = 0; k < 3; k++) begin
      step("s6");
      drop_granted();
    end
    step("s6");
    step("s6");
    rst = 1'b1;
    step("s6");
    rst          = 1'b0;
    bus.req      = '0;
    bus.blk_done = 1'b1;
    step("s6");
    bus.blk_done = 1'b0;
    chk("s6_rv",    32'(bus.res_valid), 32'h0);
    chk("s6_busy",  32'(bus.busy),      32'h0);
    chk("s6_start", 32'(bus.blk_start), 32'h0);
    step("s6");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drop_granted();
      if ($urandom_range(0, 2) == 0) bus.req = NREQ'($urandom);
      bus.req_data   = (NREQ*DW)'($urandom);
      bus.blk_done   = ($urandom_range(0, 3) == 0);
      bus.blk_result = DW'($urandom);
      bus.res_ready  = ($urandom_range(0, 1) == 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/block_scheduler.md
BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 Parameter DW, 4, operand and result width in bits.
REQ-002 Parameter NREQ, 4, number of requesters; each requester owns one operand slot of the compute block.
REQ-003 Parameter TMO, 15, maximum number of WAIT cycles before timeout; legal range 1..255.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  NREQ  per-requester load request; bit i requests a load into slot i.
REQ-008 req_data  in  NREQ*DW  packed operands; slice i belongs to requester i.
REQ-009 gnt  out  NREQ  one-hot grant, registered; at most one bit is high per cycle.
REQ-010 op_load  out  1  single-cycle slot-write strobe to the compute block.
REQ-011 op_sel  out  2  index of the slot being written.
REQ-012 op_data  out  DW  operand being written.
REQ-013 blk_start  out  1  single-cycle compute-start pulse.
REQ-014 blk_done  in  1  compute-complete pulse from the block.
REQ-015 blk_result  in  DW  block result; valid in the cycle blk_done is high.
REQ-016 res_valid  out  1  result-available flag.
REQ-017 res_data  out  DW  captured result.
REQ-018 res_ready  in  1  consumer accepts the result.
REQ-019 busy  out  1  high in any state other than COLLECT.
REQ-020 err_tmo  out  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have exactly four states: COLLECT, START, WAIT and HOLD.
REQ-022 The block SHALL keep a loaded mask of NREQ bits; a slot whose mask bit is set is excluded from arbitration.
REQ-023 In COLLECT, the block SHALL grant one eligible request per cycle in round-robin order, searching from rr_ptr upward with wrap-around.
REQ-024 A grant SHALL, in the next cycle: assert gnt[i] and op_load, drive op_sel=i and op_data=req_data slice i, set mask bit i, and set rr_ptr to (i+1) mod NREQ.
REQ-025 req SHALL be level-sensitive; a requester drops req after seeing its gnt, and a request still held after its slot is loaded is ignored.
REQ-026 When the mask becomes all-ones, the FSM SHALL go to START; when a grant completes the mask in cycle N, blk_start SHALL pulse in cycle N+1.
REQ-027 START SHALL last exactly one cycle and then go to WAIT, with the timeout counter cleared.
REQ-028 In WAIT, blk_done SHALL capture blk_result into res_data and move the FSM to HOLD with res_valid=1 in the next cycle.
REQ-029 In WAIT without blk_done, the counter SHALL increment; when it reaches TMO, the block SHALL set err_tmo, clear the mask and return to COLLECT without asserting res_valid.
REQ-030 If blk_done arrives in the same cycle the counter reaches TMO, blk_done SHALL take priority and no timeout is raised.
REQ-031 In HOLD, res_valid and res_data SHALL stay stable until res_valid and res_ready are both high; that cycle SHALL clear the mask and return to COLLECT.
REQ-032 A grant SHALL be possible in the cycle after the result handshake.
REQ-033 blk_done outside WAIT SHALL be ignored.
REQ-034 gnt and op_load SHALL be zero in START, WAIT and HOLD.
REQ-035 rr_ptr SHALL be retained across transactions.
REQ-036 err_tmo SHALL be cleared only by rst.

Reset
REQ-037 With rst high at a rising edge, the FSM SHALL be in COLLECT, the mask and rr_ptr 0, the counter 0, and gnt, op_load, op_sel, op_data, blk_start, res_valid, res_data, busy and err_tmo all 0.
REQ-038 Reset asserted mid-transaction, in any state, SHALL abandon the transaction; no blk_start or res_valid SHALL follow.

Structure
REQ-039 The state encoding enum, DW, NREQ, the default TMO and the op_sel width SHALL live in the shared package block_pkg.
REQ-040 The round-robin grant logic SHALL be one sub-module, rr_arbiter (inputs: request, mask, pointer; output: one-hot grant); everything else stays flat.

Verification
REQ-041 Scenario 1: req=4'b1111 with slices 1,2,3,4 from reset -> grants in order slot0,1,2,3 on consecutive cycles; blk_start on the following cycle; blk_done with result 4'hA -> res_valid=1 and res_data=4'hA.
REQ-042 Scenario 2: after scenario 1 ends with rr_ptr=0, req=4'b0110 and then req=4'b1001 -> grants slot1,2,3,0; the mask fills and exactly one blk_start follows.
REQ-043 Scenario 3: TMO=3 and no blk_done -> err_tmo=1 on the 3rd WAIT cycle; FSM returns to COLLECT; res_valid never rises.
REQ-044 Scenario 4: blk_done in the same cycle the counter reaches TMO -> res_valid=1 and err_tmo stays 0.
REQ-045 Scenario 5: res_ready held low for 10 cycles in HOLD -> res_valid and res_data stable throughout; a new req gets no grant until the handshake.
REQ-046 Scenario 6: rst pulsed in WAIT, then blk_done arrives -> all outputs 0, no res_valid, FSM in COLLECT.
